// File: rtl/fork_join_pkg.sv
// Shared types and default delays for the fork/join delay stage.
package fork_join_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2,
    JOIN  = 2'd3
  } state_t;

  localparam int DEF_D1 = 10;
  localparam int DEF_D2 = 12;
  localparam int DEF_CW = 8;

endpackage

// File: rtl/fork_join_delay_stage_delay_counter.sv
// Loadable down-counter with a terminal-count flag; saturates at zero.
module delay_counter
  import fork_join_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fork_join_delay_stage.sv
// Two-branch timed fork/join: ret1 follows the input pair after D1 cycles,
// ret2 follows D2 cycles after ret1 actually changes.
//
// state | meaning
// IDLE  | waiting for an input change or a pending trigger
// WAIT1 | counting down to the ret1 update
// WAIT2 | ret1 changed, counting down to the ret2 update
// JOIN  | both branches finished, done pulses on exit
module fork_join_delay_stage
  import fork_join_pkg::*;
#(
  parameter int W  = 4,
  parameter int D1 = DEF_D1,
  parameter int D2 = DEF_D2,
  parameter int CW = DEF_CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] value1,
  input  logic [W-1:0] value2,
  output logic [W-1:0] ret1,
  output logic [W-1:0] ret2,
  output logic         busy,
  output logic         done,
  output logic         skipped
);

  localparam logic [CW-1:0] LOAD1 = CW'(D1 - 1);
  localparam logic [CW-1:0] LOAD2 = CW'(D2 - 1);

  if (D1 < 1 || D1 > (1 << CW) - 1) begin : g_bad_d1
    $error("fork_join_delay_stage: D1 out of range");
  end
  if (D2 < 1 || D2 > (1 << CW) - 1) begin : g_bad_d2
    $error("fork_join_delay_stage: D2 out of range");
  end

  state_t        state, state_next;
  logic [W-1:0]  prev1, prev2, snap1, snap2, pend1, pend2;
  logic          pending, evt;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_val;
  logic          take_snap, upd_ret1, upd_ret2, set_done, set_skip;

  assign evt  = (value1 != prev1) || (value2 != prev2);
  assign busy = (state != IDLE);

  delay_counter #(.CW(CW)) u_delay_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = LOAD1;
    take_snap  = 1'b0;
    upd_ret1   = 1'b0;
    upd_ret2   = 1'b0;
    set_done   = 1'b0;
    set_skip   = 1'b0;
    case (state)
      IDLE: begin
        if (evt || pending) begin
          take_snap  = 1'b1;
          cnt_load   = 1'b1;
          state_next = WAIT1;
        end
      end
      WAIT1: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          upd_ret1 = 1'b1;
          // branch B only runs when ret1 really moves
          if (snap1 != ret1) begin
            cnt_load   = 1'b1;
            cnt_val    = LOAD2;
            state_next = WAIT2;
          end else begin
            set_skip   = 1'b1;
            state_next = JOIN;
          end
        end
      end
      WAIT2: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          upd_ret2   = 1'b1;
          state_next = JOIN;
        end
      end
      JOIN: begin
        set_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prev1   <= '0;
      prev2   <= '0;
      snap1   <= '0;
      snap2   <= '0;
      pend1   <= '0;
      pend2   <= '0;
      pending <= 1'b0;
      ret1    <= '0;
      ret2    <= '0;
      done    <= 1'b0;
      skipped <= 1'b0;
    end else begin
      state <= state_next;
      prev1 <= value1;
      prev2 <= value2;
      if (take_snap) begin
        snap1   <= evt ? value1 : pend1;
        snap2   <= evt ? value2 : pend2;
        pending <= 1'b0;
      end else if (evt) begin
        pend1   <= value1;
        pend2   <= value2;
        pending <= 1'b1;
      end
      if (upd_ret1) ret1 <= snap1;
      if (upd_ret2) ret2 <= snap2;
      done    <= set_done;
      skipped <= set_skip;
    end
  end

endmodule
